pes_ripco_ext: RTL

Downstream consumer of the 2-bit ripple counter (clk, reset, q[1:0]). It samples the counter's asynchronous q outputs into its own clock domain and rejects ripple transients. It tracks the filtered count, extends it with an EXT_W-bit wrap counter, flags illegal count steps, and raises a valid/ready threshold event for the control logic.

---
 rtl/pes_ripco_ext.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pes_ripco_ext.sv
// pes_ripco_ext: samples an asynchronous 2-bit ripple counter and rejects ripple
// transients. It tracks the filtered count, extends it with a wrap counter, flags
// illegal steps, and raises a valid/ready threshold event.
module pes_ripco_ext #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int EXT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       q_in,
  input  logic             clr,
  input  logic [EXT_W-1:0] thresh,
  output logic [EXT_W+1:0] count,
  output logic             wrap_pulse,
  output logic             step_err,
  output logic             thr_valid,
  input  logic             thr_ready
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

  // Synchronizer chain: stage 0 samples q_in, the last stage feeds the filter.
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  q_s;

  // Filter state.
  logic [1:0]        cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              accept_s;

  // Tracking state.
  logic [1:0]       q_filt_q, q_filt_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic [EXT_W-1:0] ext_inc_s;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             thr_valid_q, thr_valid_d;
  logic             match_s;

  assign q_s       = sync_q[SYNC_STAGES-1];
  assign accept_s  = (stab_q == STAB_MAX);
  assign ext_inc_s = ext_q + EXT_W'(1);

  // Plain flop chain, nothing between stages, so each bit gets full resolution time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], q_in};
    end
  end

  // Stability filter: restart the count whenever the synchronized value moves.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (q_s != cand_q) begin
      cand_d = q_s;
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
    end else begin
      stab_d = stab_q;
    end
  end

  // Step classification of the accepted value plus threshold handshake and clear.
  always_comb begin
    q_filt_d    = q_filt_q;
    ext_d       = ext_q;
    wrap_d      = 1'b0;
    err_d       = err_q;
    match_s     = 1'b0;
    thr_valid_d = thr_valid_q;

    if (accept_s && (cand_q != q_filt_q)) begin
      if ((q_filt_q == 2'd3) && (cand_q == 2'd0)) begin
        q_filt_d = 2'd0;
        ext_d    = ext_inc_s;
        wrap_d   = 1'b1;
        match_s  = (ext_inc_s == thresh);
      end else if (cand_q == (q_filt_q + 2'd1)) begin
        q_filt_d = cand_q;
      end else begin
        // Skip or backward step: follow the counter but remember the fault.
        q_filt_d = cand_q;
        err_d    = 1'b1;
      end
    end else begin
      q_filt_d = q_filt_q;
    end

    if (thr_valid_q && thr_ready) begin
      thr_valid_d = 1'b0;
    end else begin
      thr_valid_d = thr_valid_q;
    end

    // A match in the handshake cycle wins, so the event stays pending.
    if (match_s) begin
      thr_valid_d = 1'b1;
    end else begin
      thr_valid_d = thr_valid_d;
    end

    // clr discards any same-cycle event but leaves q_filt tracking the counter.
    if (clr) begin
      ext_d       = '0;
      err_d       = 1'b0;
      wrap_d      = 1'b0;
      thr_valid_d = 1'b0;
    end else begin
      ext_d = ext_d;
    end
  end

  // State registers for the filter and tracking logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q      <= 2'd0;
      stab_q      <= '0;
      q_filt_q    <= 2'd0;
      ext_q       <= '0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      thr_valid_q <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      q_filt_q    <= q_filt_d;
      ext_q       <= ext_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
      thr_valid_q <= thr_valid_d;
    end
  end

  assign count      = {ext_q, q_filt_q};
  assign wrap_pulse = wrap_q;
  assign step_err   = err_q;
  assign thr_valid  = thr_valid_q;

endmodule
